operand_loader: RTL and testbench
=================================

# operand_loader

Upstream feeder for the operand/opcode dual-port RAM consumed by `Control`. It accepts a stream of (A, B, opcode) word triples over a valid/ready handshake and writes operands to consecutive RAM words from `OPND_BASE`. It writes opcodes from `OP_BASE`, then writes the `-1` terminator that `Control` uses to stop. Until the batch is fully written it holds `Control` in reset through `ctrl_rst_n`, then releases it.

## Interface
- `DATA_W`, 32, RAM word width.
- `ADDR_W`, 8, RAM address width.
- `OPND_BASE`, 0, first operand address; operands stored A0,B0,A1,B1,...
- `OP_BASE`, 100, first opcode address.
- `MAX_OPS`, 49, maximum operations per batch; the terminator must fit below `OP_BASE`.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a batch; honoured only in IDLE or DONE.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `in_data`  in  DATA_W  stream word.
- `in_last`  in  1  marks the final opcode word of the batch; ignored on A/B words.
- `wea`  out  1  RAM port-A write enable.
- `addra`  out  ADDR_W  RAM port-A address.
- `dina`  out  DATA_W  RAM port-A data.
- `ctrl_rst_n`  out  1  active-low reset to `Control`; 0 while loading.
- `done`  out  1  batch written; level output.
- `op_count`  out  6  number of complete triples written in the current batch.
- `err_ovf`  out  1  sticky: the `MAX_OPS` limit was reached without `in_last`.
- `err_term`  out  1  sticky: an operand word equal to `-1` was accepted.

## Operation
- States and transitions:
  - IDLE: `start` → GET_A.
  - GET_A: handshake → GET_B.
  - GET_B: handshake → GET_OP.
  - GET_OP: handshake → TERM if `in_last` or `op_count+1 == MAX_OPS`, else GET_A.
  - TERM: unconditional → DONE after one cycle.
  - DONE: `start` → GET_A.
- Handshake: a word transfers at a rising edge with `in_valid && in_ready`. `in_ready` is 1 exactly in GET_A, GET_B and GET_OP, with no back-pressure inside those states.
- Write addresses for operation index k (0-based):
  - A word → `OPND_BASE+2k`.
  - B word → `OPND_BASE+2k+1`.
  - opcode → `OP_BASE+k`.
  - Address arithmetic is `ADDR_W` bits and never wraps for legal parameters.
- The opcode word is stored as all `DATA_W` bits, unmodified.
- `op_count` increments on each opcode handshake.
- TERM writes `{DATA_W{1'b1}}` to `OPND_BASE+2*op_count`.
- `err_ovf` sets when the transition to TERM is caused by the limit with `in_last`=0.
- `err_term` sets on an A or B handshake where `in_data` is all ones. The word is still written.
- In DONE: `done`=1 and `ctrl_rst_n`=1; stream words are refused.
- `start` in DONE:
  - Clears `op_count`, `done`, `err_ovf` and `err_term`.
  - Drives `ctrl_rst_n`=0 and re-enters GET_A.
- `start` in any loading state is ignored.
- `rst` mid-batch aborts immediately. Words already written stay in RAM, no terminator is written, and `Control` stays in reset.

## Timing
- Reset values, all outputs: `in_ready` 0, `wea` 0, `addra` 0, `dina` 0, `ctrl_rst_n` 0, `done` 0, `op_count` 0, `err_ovf` 0, `err_term` 0; state IDLE.
- `wea`, `addra` and `dina` are registered. A handshake at edge t gives `wea`=1 with that address and data for the single cycle after edge t. `wea` returns to 0 unless another handshake occurred at t+1.
- Back-to-back handshakes give one write per cycle; throughput is 3 cycles per operation with continuous `in_valid`.
- Terminator write: the cycle after the TERM edge.
- `done` and `ctrl_rst_n` rise together in the cycle after the terminator `wea` pulse. This guarantees the terminator is in RAM before `Control` leaves reset.
- `ctrl_rst_n` falls the cycle after `start` is sampled in DONE.
- `in_ready` rises the cycle after `start` is sampled.
- `in_ready` falls in the cycle after the final opcode handshake.

## Test plan
- Two operations, continuous valid:
  - After `start`, send 5,3,op 0, then 7,2,op 1 with `in_last`.
  - Expect writes (0,5) (1,3) (100,0) (2,7) (3,2) (101,1), then (4,FFFFFFFF).
  - Expect `done`=1 and `ctrl_rst_n`=1 one cycle later, and `op_count`=2.
- Bubbles: toggle `in_valid` every other cycle during the same batch. Expect an identical write sequence with no `wea` pulse on idle cycles.
- Overflow: `MAX_OPS`=3 and `in_last` never asserted. Expect the terminator at address 6, `err_ovf`=1, `op_count`=3, and `in_ready`=0 after the third opcode.
- Operand -1: send A=FFFFFFFF. Expect it written at address 0 and `err_term`=1 through DONE. The next `start` clears `err_term`.
- Reset mid-batch: assert `rst` after the B handshake. Expect all outputs at reset values next cycle and no write to address 100 or terminator.
- Restart: `start` in DONE, then a 1-op batch. Expect `ctrl_rst_n` to drop, writes at 0, 1, 100, terminator at 2, and `op_count`=1.

Source files
------------

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - streams (A, B, opcode) triples into the operand/opcode RAM and appends the -1 terminator
// Control is held in reset until the terminator write has completed.
module operand_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int OPND_BASE = 0,
  parameter int OP_BASE   = 100,
  parameter int MAX_OPS   = 49
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              ctrl_rst_n,
  output logic              done,
  output logic [5:0]        op_count,
  output logic              err_ovf,
  output logic              err_term
);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_OP, TERM, DONE} state_t;

  state_t              state_q, state_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dina_q, dina_d;
  logic                ctrl_rst_n_q, ctrl_rst_n_d;
  logic                done_q, done_d;
  logic [5:0]          op_count_q, op_count_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_term_q, err_term_d;

  logic                hs;
  logic                at_limit;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   opnd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
      ctrl_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      op_count_q   <= '0;
      err_ovf_q    <= 1'b0;
      err_term_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
      ctrl_rst_n_q <= ctrl_rst_n_d;
      done_q       <= done_d;
      op_count_q   <= op_count_d;
      err_ovf_q    <= err_ovf_d;
      err_term_q   <= err_term_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wea_d        = 1'b0;
    addra_d      = addra_q;
    dina_d       = dina_q;
    ctrl_rst_n_d = ctrl_rst_n_q;
    done_d       = done_q;
    op_count_d   = op_count_q;
    err_ovf_d    = err_ovf_q;
    err_term_d   = err_term_q;

    in_ready  = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_OP);
    hs        = in_valid && in_ready;
    at_limit  = (int'(op_count_q) + 1 == MAX_OPS);
    idx       = ADDR_W'(op_count_q);
    opnd_addr = ADDR_W'(OPND_BASE) + (idx << 1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = GET_A;
          op_count_d   = '0;
          done_d       = 1'b0;
          ctrl_rst_n_d = 1'b0;
          err_ovf_d    = 1'b0;
          err_term_d   = 1'b0;
        end else if (state_q == DONE) begin
          // Raised one cycle after the terminator write so it is in RAM first
          done_d       = 1'b1;
          ctrl_rst_n_d = 1'b1;
        end
      end
      GET_A, GET_B: begin
        if (hs) begin
          wea_d   = 1'b1;
          addra_d = (state_q == GET_A) ? opnd_addr : opnd_addr + ADDR_W'(1);
          dina_d  = in_data;
          if (in_data == {DATA_W{1'b1}}) err_term_d = 1'b1;
          state_d = (state_q == GET_A) ? GET_B : GET_OP;
        end
      end
      GET_OP: begin
        if (hs) begin
          wea_d      = 1'b1;
          addra_d    = ADDR_W'(OP_BASE) + idx;
          dina_d     = in_data;
          op_count_d = op_count_q + 6'd1;
          if (in_last || at_limit) state_d = TERM;
          else                     state_d = GET_A;
          if (!in_last && at_limit) err_ovf_d = 1'b1;
        end
      end
      TERM: begin
        wea_d   = 1'b1;
        addra_d = opnd_addr;
        dina_d  = {DATA_W{1'b1}};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wea        = wea_q;
  assign addra      = addra_q;
  assign dina       = dina_q;
  assign ctrl_rst_n = ctrl_rst_n_q;
  assign done       = done_q;
  assign op_count   = op_count_q;
  assign err_ovf    = err_ovf_q;
  assign err_term   = err_term_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader
// Uses MAX_OPS=3 so the overflow case is reachable in a short run.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        wea;
  logic [7:0]  addra;
  logic [31:0] dina;
  logic        ctrl_rst_n;
  logic        done;
  logic [5:0]  op_count;
  logic        err_ovf;
  logic        err_term;

  int checks = 0;
  int passed = 0;
  logic [39:0] wlog[$];
  logic [39:0] exp_q[$];

  operand_loader #(.DATA_W(32), .ADDR_W(8), .OPND_BASE(0), .OP_BASE(100), .MAX_OPS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .wea(wea), .addra(addra), .dina(dina),
    .ctrl_rst_n(ctrl_rst_n), .done(done), .op_count(op_count),
    .err_ovf(err_ovf), .err_term(err_term)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wea) wlog.push_back({addra, dina});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed %h expected %h", tag, obs, expv);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(wlog[i]), 64'(exp_q[i]));
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int tries = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) chk("hs_timeout", 64'(tries), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic exp2ops();
    exp_q = {};
    exp_q.push_back({8'd0,   32'd5});
    exp_q.push_back({8'd1,   32'd3});
    exp_q.push_back({8'd100, 32'd0});
    exp_q.push_back({8'd2,   32'd7});
    exp_q.push_back({8'd3,   32'd2});
    exp_q.push_back({8'd101, 32'd1});
    exp_q.push_back({8'd4,   32'hFFFFFFFF});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_ctrl_rst_n", ctrl_rst_n, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {op_count, err_ovf, err_term}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    // Two operations, continuous valid
    wlog = {};
    pulse_start();
    chk("t1_in_ready_up", in_ready, 1);
    send(32'd5, 0); send(32'd3, 0); send(32'd0, 0);
    send(32'd7, 0); send(32'd2, 0); send(32'd1, 1);
    chk("t1_in_ready_fall", in_ready, 0);
    @(negedge clk);
    chk("t1_term_wea", {wea, addra, dina}, {1'b1, 8'd4, 32'hFFFFFFFF});
    chk("t1_done_not_yet", {done, ctrl_rst_n}, 2'b00);
    @(negedge clk);
    chk("t1_done", {done, ctrl_rst_n}, 2'b11);
    chk("t1_op_count", op_count, 2);
    chk("t1_wea_low", wea, 0);
    @(negedge clk);
    exp2ops();
    cmp_log("t1");

    // Same batch with bubbles every other cycle
    wlog = {};
    pulse_start();
    chk("t2_ctrl_rst_n_drop", {ctrl_rst_n, done, op_count}, 0);
    send(32'd5, 0); @(negedge clk);
    send(32'd3, 0); @(negedge clk);
    send(32'd0, 0); @(negedge clk);
    send(32'd7, 0); @(negedge clk);
    send(32'd2, 0); @(negedge clk);
    send(32'd1, 1);
    repeat (3) @(negedge clk);
    chk("t2_done", {done, ctrl_rst_n, op_count}, {2'b11, 6'd2});
    cmp_log("t2");

    // Overflow: three ops without in_last
    wlog = {};
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      send(32'(10 + k), 0); send(32'(20 + k), 0); send(32'(30 + k), 0);
    end
    chk("t3_in_ready_fall", in_ready, 0);
    repeat (2) @(negedge clk);
    chk("t3_err_ovf", err_ovf, 1);
    chk("t3_op_count", op_count, 3);
    chk("t3_done", done, 1);
    chk("t3_nwrites", 64'(wlog.size()), 10);
    if (wlog.size() == 10) chk("t3_term", 64'(wlog[9]), 64'({8'd6, 32'hFFFFFFFF}));
    chk("t3_op2", wlog.size() > 8 ? 64'(wlog[8]) : 64'd0, 64'({8'd102, 32'd32}));

    // Operand -1
    wlog = {};
    pulse_start();
    chk("t4_errs_cleared", {err_ovf, err_term}, 2'b00);
    send(32'hFFFFFFFF, 0);
    chk("t4_err_term_set", err_term, 1);
    send(32'd1, 0); send(32'd2, 1);
    repeat (2) @(negedge clk);
    chk("t4_err_term_done", {done, err_term}, 2'b11);
    chk("t4_first_write", wlog.size() > 0 ? 64'(wlog[0]) : 64'd0, 64'({8'd0, 32'hFFFFFFFF}));

    // Restart from DONE with a one-op batch
    wlog = {};
    pulse_start();
    chk("t6_restart", {ctrl_rst_n, done, err_term, op_count}, 0);
    send(32'd11, 0); send(32'd12, 0); send(32'd13, 1);
    repeat (2) @(negedge clk);
    chk("t6_done", {done, ctrl_rst_n, op_count}, {2'b11, 6'd1});
    exp_q = {};
    exp_q.push_back({8'd0,   32'd11});
    exp_q.push_back({8'd1,   32'd12});
    exp_q.push_back({8'd100, 32'd13});
    exp_q.push_back({8'd2,   32'hFFFFFFFF});
    cmp_log("t6");

    // Reset after the B handshake
    wlog = {};
    pulse_start();
    send(32'd9, 0); send(32'd8, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_outputs", {in_ready, wea, addra, dina, ctrl_rst_n, done, op_count, err_ovf, err_term}, 0);
    repeat (4) @(negedge clk);
    chk("t5_still_reset", {ctrl_rst_n, done, in_ready}, 0);
    exp_q = {};
    exp_q.push_back({8'd0, 32'd9});
    exp_q.push_back({8'd1, 32'd8});
    cmp_log("t5");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
